// File: rtl/arb_pkg.sv
// Shared arbiter definitions: requester vector/index types and one-hot helpers.
// Imported by the round-robin arbiter and by its grant dispatcher.
package arb_pkg;

    localparam int unsigned N_REQ_DEF = 8;

    typedef logic [N_REQ_DEF-1:0]         req_vec_t;
    typedef logic [$clog2(N_REQ_DEF)-1:0] req_id_t;

    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    function automatic logic is_onehot(input req_vec_t v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    // Index of the lowest set bit; 0 for an all-zero vector.
    function automatic req_id_t onehot_to_idx(input req_vec_t v);
        req_id_t idx;
        idx = '0;
        for (int unsigned i = N_REQ_DEF; i > 0; i--) begin
            if (v[i-1]) begin
                idx = req_id_t'(i - 1);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_sync_fifo.sv
// Small synchronous FIFO holding {id, data} entries for the grant dispatcher.
// Head word reads as zero while empty so downstream never sees stale entries.
module arb_sync_fifo #(
    parameter int unsigned WIDTH = 19,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Storage carries no reset; validity is tracked entirely by cnt.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/arb_grant_dispatch.sv
// Captures the payload of the granted requester into an output FIFO, acks the
// winner one cycle later, flags multi-hot grants and counts accepted transfers.
module arb_grant_dispatch
    import arb_pkg::*;
#(
    parameter int unsigned N_REQ  = 8,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          grant,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          ack,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [$clog2(N_REQ)-1:0]  out_id,
    output logic                      full,
    output logic                      err_multi,
    output logic [CNT_W-1:0]          xfer_cnt
);

    localparam int unsigned ID_W    = $clog2(N_REQ);
    localparam int unsigned ENTRY_W = ID_W + DATA_W;
    localparam int unsigned FCNT_W  = $clog2(DEPTH) + 1;

    req_vec_t            grant_v;
    logic                grant_onehot;
    logic                grant_multi;
    logic [ID_W-1:0]     grant_idx;
    logic [DATA_W-1:0]   grant_data;
    logic                push;
    logic                pop;
    logic [ENTRY_W-1:0]  head;
    logic                fifo_empty;
    logic [FCNT_W-1:0]   fifo_count;

    assign grant_v      = req_vec_t'(grant);
    assign grant_onehot = is_onehot(grant_v);
    assign grant_multi  = (grant != '0) && !grant_onehot;
    assign grant_idx    = ID_W'(onehot_to_idx(grant_v));
    assign grant_data   = req_data[grant_idx*DATA_W +: DATA_W];

    // Space is judged on registered occupancy only: a pop in the same cycle
    // does not make room, so a grant while full is simply left pending.
    assign push = grant_onehot && (fifo_count < FCNT_W'(DEPTH));
    assign pop  = out_valid && out_ready;

    arb_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata ({grant_idx, grant_data}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign out_valid          = !fifo_empty;
    assign {out_id, out_data} = head;

    always_ff @(posedge clk) begin
        if (reset) begin
            ack       <= '0;
            err_multi <= 1'b0;
            xfer_cnt  <= '0;
        end else begin
            ack       <= push ? grant : '0;
            err_multi <= err_multi | grant_multi;
            if (push) begin
                xfer_cnt <= xfer_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_arb_grant_dispatch.sv
// Self-checking bench for arb_grant_dispatch: directed vectors, corner
// sequences and randomized traffic against a queue-based reference model.
module tb_arb_grant_dispatch;

    logic          clk;
    logic          reset;
    logic [7:0]    grant;
    logic [127:0]  req_data;
    logic [7:0]    ack;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_data;
    logic [2:0]    out_id;
    logic          full;
    logic          err_multi;
    logic [15:0]   xfer_cnt;

    arb_grant_dispatch #(
        .N_REQ  (8),
        .DATA_W (16),
        .DEPTH  (2),
        .CNT_W  (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .grant     (grant),
        .req_data  (req_data),
        .ack       (ack),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .full      (full),
        .err_multi (err_multi),
        .xfer_cnt  (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  id;
        logic [15:0] data;
    } ent_t;

    typedef struct {
        logic [7:0]  g;
        logic [15:0] d;
        logic        r;
        logic [7:0]  ack;
        logic        v;
        logic [2:0]  id;
        logic [15:0] od;
        logic        f;
        logic        e;
        logic [15:0] cnt;
    } vec_t;

    int   errors = 0;
    int   checks = 0;

    ent_t        mq[$];
    logic [7:0]  m_ack;
    logic        m_err;
    logic [15:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [127:0] mkdata(input logic [7:0] g, input logic [15:0] d);
        logic [127:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i*16 +: 16] = 16'($urandom);
            if (g[i]) r[i*16 +: 16] = d;
        end
        return r;
    endfunction

    // One clock: drive inputs, advance the model by the stated rules, compare.
    task automatic step(input logic [7:0] g, input logic [127:0] d, input logic r, input logic rst);
        int   n;
        int   idx;
        logic do_pop;
        logic do_push;
        ent_t e;
        grant     = g;
        req_data  = d;
        out_ready = r;
        reset     = rst;
        @(posedge clk);
        #1;
        if (rst) begin
            mq.delete();
            m_ack = '0;
            m_err = 1'b0;
            m_cnt = '0;
        end else begin
            n       = mq.size();
            do_pop  = (n > 0) && r;
            do_push = ($countones(g) == 1) && (n < 2);
            idx = 0;
            for (int i = 0; i < 8; i++) if (g[i]) idx = i;
            if (do_pop) e = mq.pop_front();
            if (do_push) begin
                e.id   = 3'(idx);
                e.data = d[idx*16 +: 16];
                mq.push_back(e);
            end
            m_ack = do_push ? g : 8'h00;
            if ($countones(g) > 1) m_err = 1'b1;
            if (do_push) m_cnt = m_cnt + 16'd1;
        end
        chk("m_ack", ack, m_ack);
        chk("m_valid", out_valid, mq.size() != 0);
        chk("m_full", full, mq.size() == 2);
        chk("m_err", err_multi, m_err);
        chk("m_cnt", xfer_cnt, m_cnt);
        chk("m_id", out_id, mq.size() != 0 ? mq[0].id : 3'd0);
        chk("m_data", out_data, mq.size() != 0 ? mq[0].data : 16'd0);
    endtask

    vec_t vecs[16];

    initial begin
        logic [7:0] g;
        // Test plan 1..4, cumulative counter values
        vecs[0]  = '{8'h04, 16'hA5A5, 1'b0, 8'h04, 1'b1, 3'd2, 16'hA5A5, 1'b0, 1'b0, 16'd1};
        vecs[1]  = '{8'h00, 16'h0000, 1'b1, 8'h00, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 16'd1};
        vecs[2]  = '{8'h01, 16'h0011, 1'b0, 8'h01, 1'b1, 3'd0, 16'h0011, 1'b0, 1'b0, 16'd2};
        vecs[3]  = '{8'h02, 16'h0022, 1'b0, 8'h02, 1'b1, 3'd0, 16'h0011, 1'b1, 1'b0, 16'd3};
        vecs[4]  = '{8'h08, 16'h0088, 1'b0, 8'h00, 1'b1, 3'd0, 16'h0011, 1'b1, 1'b0, 16'd3};
        vecs[5]  = '{8'h00, 16'h0000, 1'b1, 8'h00, 1'b1, 3'd1, 16'h0022, 1'b0, 1'b0, 16'd3};
        vecs[6]  = '{8'h00, 16'h0000, 1'b1, 8'h00, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 16'd3};
        vecs[7]  = '{8'h01, 16'h1001, 1'b1, 8'h01, 1'b1, 3'd0, 16'h1001, 1'b0, 1'b0, 16'd4};
        vecs[8]  = '{8'h02, 16'h2002, 1'b1, 8'h02, 1'b1, 3'd1, 16'h2002, 1'b0, 1'b0, 16'd5};
        vecs[9]  = '{8'h04, 16'h3003, 1'b1, 8'h04, 1'b1, 3'd2, 16'h3003, 1'b0, 1'b0, 16'd6};
        vecs[10] = '{8'h08, 16'h4004, 1'b1, 8'h08, 1'b1, 3'd3, 16'h4004, 1'b0, 1'b0, 16'd7};
        vecs[11] = '{8'h00, 16'h0000, 1'b1, 8'h00, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 16'd7};
        vecs[12] = '{8'h03, 16'h5555, 1'b1, 8'h00, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 16'd7};
        vecs[13] = '{8'h00, 16'h0000, 1'b1, 8'h00, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 16'd7};
        vecs[14] = '{8'h80, 16'h8080, 1'b0, 8'h80, 1'b1, 3'd7, 16'h8080, 1'b0, 1'b1, 16'd8};
        vecs[15] = '{8'h00, 16'h0000, 1'b1, 8'h00, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 16'd8};

        grant = '0; req_data = '0; out_ready = 1'b0; reset = 1'b1;
        step(8'h00, '0, 1'b0, 1'b1);
        chk("rst_ack", ack, 8'h00);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_full", full, 1'b0);
        chk("rst_err", err_multi, 1'b0);
        chk("rst_cnt", xfer_cnt, 16'd0);

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].g, mkdata(vecs[i].g, vecs[i].d), vecs[i].r, 1'b0);
            chk($sformatf("v%0d_ack", i), ack, vecs[i].ack);
            chk($sformatf("v%0d_valid", i), out_valid, vecs[i].v);
            chk($sformatf("v%0d_id", i), out_id, vecs[i].id);
            chk($sformatf("v%0d_data", i), out_data, vecs[i].od);
            chk($sformatf("v%0d_full", i), full, vecs[i].f);
            chk($sformatf("v%0d_err", i), err_multi, vecs[i].e);
            chk($sformatf("v%0d_cnt", i), xfer_cnt, vecs[i].cnt);
        end

        // Fill, then reset together with a grant that would otherwise be acked
        step(8'h01, mkdata(8'h01, 16'hC001), 1'b0, 1'b0);
        step(8'h02, mkdata(8'h02, 16'hC002), 1'b0, 1'b0);
        chk("fill_full", full, 1'b1);
        step(8'h04, mkdata(8'h04, 16'hC004), 1'b0, 1'b1);
        chk("mid_rst_ack", ack, 8'h00);
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_full", full, 1'b0);
        chk("mid_rst_err", err_multi, 1'b0);
        chk("mid_rst_cnt", xfer_cnt, 16'd0);

        // Counter wrap
        for (int i = 0; i < 65535; i++) begin
            g = 8'h01 << (i % 8);
            step(g, mkdata(g, 16'(i)), 1'b1, 1'b0);
        end
        chk("wrap_pre_cnt", xfer_cnt, 16'hFFFF);
        step(8'h20, mkdata(8'h20, 16'hBEEF), 1'b1, 1'b0);
        chk("wrap_cnt", xfer_cnt, 16'h0000);
        chk("wrap_ack", ack, 8'h20);
        chk("wrap_id", out_id, 3'd5);
        chk("wrap_data", out_data, 16'hBEEF);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            int unsigned kind;
            kind = $urandom_range(0, 9);
            if (kind < 3)      g = 8'h00;
            else if (kind < 9) g = 8'h01 << $urandom_range(0, 7);
            else               g = 8'($urandom) | 8'h18;
            step(g, mkdata(g, 16'($urandom)), 1'($urandom_range(0, 1)), (i == 200) ? 1'b1 : 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arb_grant_dispatch.md
Name: arb_grant_dispatch

Overview:
Downstream consumer of the 8-way round-robin arbiter's one-hot grant vector. When the arbiter grants a requester, this block:
- captures that requester's payload and its index into a small output FIFO;
- pulses an acknowledge back to the winning requester;
- presents the entries to the next stage over a valid/ready interface.
It also flags illegal multi-hot grants and keeps a count of accepted transfers.

Parameters:
N_REQ, 8, number of requesters; must equal the arbiter width.
DATA_W, 16, payload width per requester.
DEPTH, 2, output FIFO entries; power of two, >= 2.
CNT_W, 16, width of the accepted-transfer counter.

Ports:
clk  input  1  single clock; all logic on the rising edge.
reset  input  1  synchronous, active-high.
grant  input  N_REQ  one-hot or all-zero grant from the arbiter.
req_data  input  N_REQ*DATA_W  packed payloads; requester i occupies bits [i*DATA_W +: DATA_W].
ack  output  N_REQ  one-cycle pulse to the requester whose payload was captured.
out_valid  output  1  FIFO non-empty.
out_ready  input  1  downstream accepts the head entry when high together with out_valid.
out_data  output  DATA_W  head payload.
out_id  output  $clog2(N_REQ)  head requester index.
full  output  1  FIFO holds DEPTH entries.
err_multi  output  1  sticky: a grant with more than one bit set was seen.
xfer_cnt  output  CNT_W  count of captured grants; wraps modulo 2^CNT_W.

Behaviour:
- Reset (synchronous, active-high) clears FIFO pointers and count. Reset values: ack=0, out_valid=0, full=0, err_multi=0, xfer_cnt=0. out_data and out_id are 0 while empty; do not rely on them when out_valid=0.
- Push condition: grant is exactly one-hot AND count < DEPTH.
  - Use the registered count only; a same-cycle pop does not free space for a push.
  - On push, write {index(grant), req_data slice} to the tail.
  - ack[index] = 1 in the next cycle, for exactly one cycle; all other ack bits stay 0.
  - xfer_cnt increments by 1.
- Grant while full: no capture, no ack, no counter change. The requester stays pending and the arbiter re-grants later. Grants are never silently lost.
- Grant = 0: no action.
- Multi-hot grant: no capture, no ack. err_multi is set in the next cycle and stays high until reset.
- Pop: out_valid && out_ready advances the head; the next entry (if any) is visible in the next cycle.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and ordering is preserved.
- Latency: a grant sampled at edge N produces out_valid (if the FIFO was empty) and ack at N+1, i.e. one register stage.
- Output stability: out_data and out_id stay stable while out_valid=1 and out_ready=0.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally. Count is $clog2(DEPTH)+1 bits. full = (count == DEPTH).
- Reset mid-operation drops all FIFO contents and clears any ack due that cycle. err_multi clears.
- No combinational path from grant or out_ready to any output; all outputs are registered or derived from registered state.

Decomposition:
- Shared package arb_pkg holds:
  - N_REQ_DEF = 8;
  - typedef req_vec_t (logic [N_REQ_DEF-1:0]);
  - typedef req_id_t (logic [$clog2(N_REQ_DEF)-1:0]);
  - function onehot_to_idx (lowest set bit);
  - function is_onehot.
  The arbiter and this block both import it.
- One natural sub-module: arb_sync_fifo (parameterised width/depth, push/pop/full/empty/count). It stores {id, data}.

Test Plan:
1. After reset, grant=8'b0000_0100, req_data[2]=16'hA5A5 for one cycle, out_ready=0. Expected: ack=8'b0000_0100 for one cycle; out_valid=1, out_id=2, out_data=16'hA5A5; xfer_cnt=1.
2. out_ready=0; grants 8'b0000_0001 (data 16'h0011), then 8'b0000_0010 (data 16'h0022), then 8'b0000_1000 (data 16'h0088). Expected: full=1 after the second grant; third grant gets no ack and xfer_cnt=2. Raise out_ready: outputs id 0/16'h0011, then id 1/16'h0022 in order.
3. Hold out_ready=1 and drive the arbiter rotation 8'b0000_0001, 8'b0000_0010, 8'b0000_0100, 8'b0000_1000 on back-to-back cycles. Expected: one transfer per cycle, out_id sequence 0,1,2,3, one ack per requester, xfer_cnt=4.
4. grant=8'b0000_0011. Expected: no ack, no push, err_multi=1 next cycle and held; then a legal grant 8'b1000_0000 is accepted normally.
5. Fill to full, assert reset for one cycle mid-stream. Expected: out_valid=0, full=0, err_multi=0, xfer_cnt=0, ack=0 the cycle after reset.
6. Preload xfer_cnt to 16'hFFFF via 65535 grants, then one more grant. Expected: xfer_cnt wraps to 0; ack and data are correct.
